// File: rtl/inst_fetch_responder_pkg.sv
// Shared widths, NOP word and FSM encoding for the instruction fetch responder.
// The optional last-instruction buffer is enabled with LAST_INST_BUF_EN.
package inst_fetch_responder_pkg;

    localparam int InstAddrWidth = 32;
    localparam int InstDataWidth = 32;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic RstEnable = 1'b0;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_responder_line_buf.sv
// One-entry tag/data buffer holding the last word returned by memory.
// Only compiled when LAST_INST_BUF_EN is defined; the default build has no buffer.
`ifdef LAST_INST_BUF_EN
module inst_line_buf
    import inst_fetch_responder_pkg::*;
#(
    parameter int ADDR_W = InstAddrWidth,
    parameter int DATA_W = InstDataWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_lookup_tag,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_tag;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_tag   <= i_wr_tag;
            r_data  <= i_wr_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_data = r_data;

endmodule
`endif

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for the IF fetch port: fetches one word per request and stalls the PC meanwhile.
// Define LAST_INST_BUF_EN to add a one-entry buffer that serves repeated fetches without a memory access.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int              ADDR_W   = InstAddrWidth,
    parameter int              DATA_W   = InstDataWidth,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              stall_req,
    output logic              misalign_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_inst;
    logic              r_inst_valid;
    logic              r_misalign;
    logic              r_mem_req;
    logic              r_drop_q;

    logic              w_drop_now;
    logic              w_hit;
    logic [DATA_W-1:0] w_buf_data;

    // A flush arriving together with mem_ack still discards the word.
    assign w_drop_now = r_drop_q | flush;

`ifdef LAST_INST_BUF_EN
    logic w_buf_wr;
    assign w_buf_wr = (r_state == ST_REQ) && mem_ack && !w_drop_now;

    inst_line_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_buf_wr),
        .i_wr_tag    (r_addr_q),
        .i_wr_data   (mem_rdata),
        .i_lookup_tag(addr),
        .o_hit       (w_hit),
        .o_data      (w_buf_data)
    );
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = NOP_INST;
`endif

    always_comb begin
        stall_req = 1'b0;
        case (r_state)
            ST_IDLE: stall_req = ce & ~flush;
            ST_REQ:  stall_req = 1'b1;
            default: stall_req = 1'b0;
        endcase
    end

    // Memory handshake: mem_req rises with a stable mem_addr and is held until the
    // single-cycle mem_ack; a request is never withdrawn except by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_state      <= ST_IDLE;
            r_addr_q     <= '0;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_mem_req    <= 1'b0;
            r_drop_q     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_inst_valid <= 1'b0;
                    r_misalign   <= 1'b0;
                    if (ce && !flush) begin
                        if (is_misaligned(addr[1:0])) begin
                            r_inst     <= NOP_INST;
                            r_misalign <= 1'b1;
                            r_state    <= ST_RESP;
                        end else if (w_hit) begin
                            r_addr_q     <= addr;
                            r_inst       <= w_buf_data;
                            r_inst_valid <= 1'b1;
                            r_state      <= ST_RESP;
                        end else begin
                            r_addr_q  <= addr;
                            r_mem_req <= 1'b1;
                            r_state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_drop_q  <= 1'b0;
                        if (w_drop_now) begin
                            r_inst  <= NOP_INST;
                            r_state <= ST_IDLE;
                        end else begin
                            r_inst       <= mem_rdata;
                            r_inst_valid <= 1'b1;
                            r_state      <= ST_RESP;
                        end
                    end else if (flush) begin
                        r_drop_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_inst_valid <= 1'b0;
                    r_misalign   <= 1'b0;
                    r_state      <= ST_IDLE;
                    if (flush) begin
                        r_inst <= NOP_INST;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_drop_q  <= 1'b0;
                end
            endcase
        end
    end

    assign inst         = r_inst;
    assign inst_valid   = r_inst_valid;
    assign misalign_err = r_misalign;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_addr_q;
    assign dbg_state    = r_state;

endmodule
